// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Programmable pass counter with run/hold/done sequencing. A start request
// launches a pass that counts from 0 up to the terminal count (tc). In one-shot
// mode the pass parks in DONE; in continuous mode the counter wraps to 0 and
// keeps running. Completed passes are tallied in a saturating 8-bit counter.
//
// Optional feature macro: COUNTER_SEQ_DOWN_EN
//   Adds input dir, latched on an accepted start. dir=1 counts from tc down
//   to 0, reloading tc at start and at wrap, with 0 as the terminal value.
//   When the macro is undefined the block counts up only and dir is absent.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   level-sampled start request
//   stop      in   abort, returns to IDLE
//   pause     in   freeze counting while high
//   mode      in   0 = one-shot, 1 = continuous (latched on accepted start)
//   tc_load   in   terminal-count write strobe (IDLE/DONE only)
//   tc_in     in   terminal-count value [WIDTH]
//   dir       in   count direction (COUNTER_SEQ_DOWN_EN builds only)
//   count     out  registered count value [WIDTH]
//   busy      out  high in RUN and HOLD
//   done      out  one-cycle pulse at one-shot completion
//   wrap      out  one-cycle pulse at continuous-mode wrap
//   pass_cnt  out  completed passes, saturating at 255 [8]
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | parked, count=0, waits for start
// RUN   | counting one step per edge
// HOLD  | pause asserted, count frozen
// DONE  | one-shot pass complete, count holds terminal value
//
// Input priority: reset > stop > pause > start.
// -----------------------------------------------------------------------------
module counter_sequencer #(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic             tc_load,
  input  logic [WIDTH-1:0] tc_in,
`ifdef COUNTER_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [7:0]       pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_tc;
  logic             r_mode;
  logic             r_done;
  logic             r_wrap;
  logic [7:0]       r_pass;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_tc_nxt;
  logic             w_mode_nxt;
  logic             w_done_nxt;
  logic             w_wrap_nxt;
  logic [7:0]       w_pass_nxt;

  logic [WIDTH-1:0] w_start_cnt;
  logic [WIDTH-1:0] w_step_cnt;
  logic [WIDTH-1:0] w_wrap_cnt;
  logic             w_at_tc;
  logic             w_start_ok;
  logic [7:0]       w_pass_inc;

  // tc may only change while no pass is in flight, so RUN/HOLD always
  // finish against the value they started with.
  assign w_tc_nxt = (tc_load && (r_state == S_IDLE || r_state == S_DONE)) ? tc_in : r_tc;

  // pause outranks start, so a paused block never launches a pass.
  assign w_start_ok = start && !stop && !pause;

  assign w_pass_inc = (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;

`ifdef COUNTER_SEQ_DOWN_EN
  logic r_dir;
  logic w_dir_nxt;

  // A down pass preloads the tc that will be in effect after this edge.
  assign w_start_cnt = dir ? w_tc_nxt : '0;
  assign w_step_cnt  = r_dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
  assign w_wrap_cnt  = r_dir ? r_tc : '0;
  assign w_at_tc     = r_dir ? (r_count == '0) : (r_count == r_tc);
  assign w_dir_nxt   = ((r_state == S_IDLE || r_state == S_DONE) && w_start_ok) ? dir : r_dir;
`else
  assign w_start_cnt = '0;
  assign w_step_cnt  = r_count + WIDTH'(1);
  assign w_wrap_cnt  = '0;
  assign w_at_tc     = (r_count == r_tc);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        if (w_start_ok) begin
          w_state_nxt = S_RUN;
          w_count_nxt = w_start_cnt;
          w_mode_nxt  = mode;
          w_pass_nxt  = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (pause) begin
          w_state_nxt = S_HOLD;
        end else if (w_at_tc) begin
          w_pass_nxt = w_pass_inc;
          if (r_mode) begin
            w_count_nxt = w_wrap_cnt;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = w_step_cnt;
        end
      end
      S_HOLD: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (!pause) begin
          // resume without stepping; the next RUN edge does the increment
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (w_start_ok) begin
          w_state_nxt = S_RUN;
          w_count_nxt = w_start_cnt;
          w_mode_nxt  = mode;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_tc    <= WIDTH'(DEFAULT_TC);
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_pass  <= '0;
`ifdef COUNTER_SEQ_DOWN_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
      r_pass  <= w_pass_nxt;
`ifdef COUNTER_SEQ_DOWN_EN
      r_dir   <= w_dir_nxt;
`endif
    end
  end

  assign count    = r_count;
  assign busy     = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done     = r_done;
  assign wrap     = r_wrap;
  assign pass_cnt = r_pass;

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have parameter DEFAULT_TC, default 9, giving the terminal count loaded at reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level-sampled start request.
REQ-006 SHALL have port stop  input  1  abort request; returns the block to IDLE.
REQ-007 SHALL have port pause  input  1  freezes counting while high.
REQ-008 SHALL have port mode  input  1  0 = one-shot, 1 = continuous; latched on an accepted start.
REQ-009 SHALL have port tc_load  input  1  terminal-count write strobe.
REQ-010 SHALL have port tc_in  input  WIDTH  terminal-count value.
REQ-011 SHALL have port count  output  WIDTH  current count value, registered.
REQ-012 SHALL have port busy  output  1  high in RUN and HOLD.
REQ-013 SHALL have port done  output  1  one-cycle pulse at one-shot completion.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse at continuous-mode wrap.
REQ-015 SHALL have port pass_cnt  output  8  number of completed passes; saturates at 255.

Function
REQ-016 SHALL implement states IDLE, RUN, HOLD and DONE.
REQ-017 SHALL resolve inputs in the fixed priority reset > stop > pause > start.
REQ-018 IDLE: count=0; start -> RUN; on that edge count stays 0, mode is latched and pass_cnt clears.
REQ-019 RUN, count!=tc: count increments by 1 per edge; pause -> HOLD with count held; stop -> IDLE with count=0.
REQ-020 RUN, count==tc, one-shot: -> DONE; count holds tc; done=1 for one cycle; pass_cnt increments.
REQ-021 RUN, count==tc, continuous: stays in RUN; count<=0; wrap=1 for one cycle; pass_cnt increments.
REQ-022 HOLD: count frozen; pause low -> RUN with no increment on that edge; stop -> IDLE with count=0.
REQ-023 DONE: count holds tc; start -> RUN with count=0 and pass_cnt retained; stop -> IDLE with count=0.
REQ-024 tc_load SHALL be accepted only in IDLE or DONE and SHALL be ignored in RUN and HOLD.
REQ-025 tc=0 SHALL make every RUN edge terminal (one-shot goes to DONE after one edge; continuous wraps every edge).
REQ-026 done and wrap SHALL be registered, SHALL never be high together, and SHALL be 0 in IDLE and HOLD.
REQ-027 pass_cnt SHALL saturate at 255 and SHALL NOT wrap.

Reset
REQ-028 reset high at an edge SHALL force IDLE, count=0, busy=0, done=0, wrap=0, pass_cnt=0, tc=DEFAULT_TC and latched mode=0, from any state, including mid-RUN.

Configuration
REQ-029 With COUNTER_SEQ_DOWN_EN defined, SHALL add input dir (1 bit), latched on an accepted start; dir=1 counts from tc down to 0, loads tc at start and wrap, and treats 0 as terminal.
REQ-030 Without COUNTER_SEQ_DOWN_EN, the dir port SHALL be absent and the block SHALL count up only.

Verification
REQ-031 tc=9, mode=0, one-cycle start: count 0,1..9 over 10 edges, then done=1 for one cycle, state DONE, count=9, pass_cnt=1.
REQ-032 tc=3, mode=1, run 10 edges after start: count sequence 0,1,2,3,0,1,2,3,0,1; wrap pulses 2; pass_cnt=2.
REQ-033 pause high for 3 cycles at count=5: count stays 5, busy=1; after release the next edge gives count=5, then 6.
REQ-034 stop and start asserted together at count=7: state IDLE, count=0, busy=0, no done.
REQ-035 tc_load with tc_in=2 during RUN: ignored; the pass still ends at the old tc; the same load in DONE takes effect on the next start.
REQ-036 reset mid-RUN at count=4 with tc previously loaded as 12: next cycle count=0, IDLE, tc=9, pass_cnt=0.
